spi_cmd_seq: RTL and testbench
==============================

// Module: spi_cmd_seq
// PURPOSE
//  Upstream sequencer for spi_drv: accepts a command (word count + bits/word), streams tx words
//  one at a time into spi_drv, waits for each transfer to finish, returns each rx word downstream.
//  Sits between a host-side valid/ready source and spi_drv's start_cmd/spi_drv_rdy handshake.
// PARAMETERS
//  SPI_MAXLEN   8    data word width; must match spi_drv SPI_MAXLEN
//  MAX_WORDS    16   max words per command
//  ACK_TIMEOUT  16   cycles to wait for drv_rdy to drop after drv_start before aborting
// PORTS
//  clk          in   1                        system clock
//  rst          in   1                        asynchronous, active-high reset
//  cmd_valid    in   1                        command offered
//  cmd_ready    out  1                        command accepted when cmd_valid&cmd_ready
//  cmd_len      in   $clog2(MAX_WORDS+1)      words in command (valid 1..MAX_WORDS)
//  cmd_nbits    in   $clog2(SPI_MAXLEN)+1     bits per word (valid 1..SPI_MAXLEN)
//  tx_valid     in   1                        tx word offered
//  tx_ready     out  1                        tx word accepted
//  tx_data      in   SPI_MAXLEN               tx word
//  rx_valid     out  1                        rx word available
//  rx_ready     in   1                        downstream accepts rx word
//  rx_data      out  SPI_MAXLEN               rx word
//  rx_last      out  1                        rx word is last of command
//  busy         out  1                        state != IDLE
//  err_cmd      out  1                        1-cycle pulse: invalid command dropped
//  err_timeout  out  1                        1-cycle pulse: drv_rdy never dropped, command aborted
//  drv_start    out  1                        to spi_drv start_cmd (1-cycle pulse)
//  drv_n_clks   out  $clog2(SPI_MAXLEN)+1     to spi_drv n_clks
//  drv_tx_data  out  SPI_MAXLEN               to spi_drv tx_data
//  drv_rdy      in   1                        from spi_drv spi_drv_rdy
//  drv_rx_data  in   SPI_MAXLEN               from spi_drv rx_miso
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready (0 during rst, 1 first IDLE cycle after).
//  Reset mid-operation aborts immediately; partial rx word discarded; no err pulse.
//  All outputs registered or decoded from state register; no comb path input->output.
//  IDLE: cmd_ready=1. On handshake latch len/nbits. len==0, nbits==0 or nbits>SPI_MAXLEN:
//   err_cmd pulse next cycle, stay IDLE, no tx consumed. Else remaining<=len -> FETCH.
//  FETCH: tx_ready=1. On tx handshake latch tx_data -> START.
//  START: wait for drv_rdy=1; then drv_start=1 for exactly one cycle with drv_tx_data/drv_n_clks
//   stable that cycle (held until next START) -> WAIT_BUSY, timer cleared.
//  WAIT_BUSY: drv_rdy=0 -> WAIT_DONE. Timer reaches ACK_TIMEOUT with drv_rdy=1 -> err_timeout
//   pulse, -> IDLE; unconsumed tx words of that command are left for the source to flush.
//  WAIT_DONE: no timeout. drv_rdy=1 -> capture drv_rx_data into rx_data -> PUSH.
//  PUSH: rx_valid=1, rx_last=(remaining==1); rx_data stable until accepted. On rx_ready:
//   remaining-1; last -> IDLE else FETCH. rx_valid&rx_ready and next tx fetch never share a cycle.
//  tx_data/rx_data passed unmodified (no masking/alignment by nbits).
//  Per word min latency tx handshake -> rx_valid: 4 cycles + spi_drv transfer time.
//  rx_ready held low: no further drv_start until word accepted (single-word buffering).
//  cmd_valid ignored outside IDLE; tx_valid ignored outside FETCH.
// TESTING  (SPI_MAXLEN=8, real spi_drv CLK_DIVIDE=4, MISO tied to MOSI)
//  1 cmd len=3 nbits=8, tx EA,55,0F, rx_ready=1 -> 3 drv_start pulses, rx EA,55,0F, rx_last on 3rd only.
//  2 as 1 but rx_ready=0 for 20 cycles on word 1 -> rx_valid/rx_data held, no 2nd drv_start, tx_ready=0.
//  3 cmd nbits=9, then len=0 -> err_cmd pulse each, tx_ready never 1, busy never 1.
//  4 spi_drv replaced by stub drv_rdy=1 always -> err_timeout exactly ACK_TIMEOUT cycles after drv_start, busy=0.
//  5 rst asserted in WAIT_DONE -> all outputs 0 same cycle; after release cmd len=1 tx A5 -> rx A5 rx_last=1.
//  6 back-to-back cmds len=MAX_WORDS, nbits=4 -> drv_n_clks=4 each, 16 rx words, cmd_ready only between.

Source files
------------

// File: rtl/spi_cmd_seq.sv
// rtl/spi_cmd_seq.sv - command sequencer feeding spi_drv one word at a time
module spi_cmd_seq #(
  parameter  int SPI_MAXLEN  = 8,
  parameter  int MAX_WORDS   = 16,
  parameter  int ACK_TIMEOUT = 16,
  localparam int LEN_W       = $clog2(MAX_WORDS + 1),
  localparam int NB_W        = $clog2(SPI_MAXLEN) + 1,
  localparam int TMR_W       = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [NB_W-1:0]       cmd_nbits,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [SPI_MAXLEN-1:0] rx_data,
  output logic                  rx_last,
  output logic                  busy,
  output logic                  err_cmd,
  output logic                  err_timeout,
  output logic                  drv_start,
  output logic [NB_W-1:0]       drv_n_clks,
  output logic [SPI_MAXLEN-1:0] drv_tx_data,
  input  logic                  drv_rdy,
  input  logic [SPI_MAXLEN-1:0] drv_rx_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_PUSH
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [TMR_W-1:0] timer;
  logic             cmd_bad;

  // A command is rejected when it asks for no words, too many words, or an unsupported word size
  always_comb begin
    cmd_bad = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_WORDS)) ||
              (cmd_nbits == '0) || (cmd_nbits > NB_W'(SPI_MAXLEN));
  end

  // Sequencer FSM; every handshake output is registered alongside the state transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      remaining   <= '0;
      timer       <= '0;
      cmd_ready   <= 1'b0;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_last     <= 1'b0;
      busy        <= 1'b0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
      drv_start   <= 1'b0;
      drv_n_clks  <= '0;
      drv_tx_data <= '0;
    end else begin
      drv_start   <= 1'b0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (cmd_bad) begin
              err_cmd <= 1'b1;
            end else begin
              remaining  <= cmd_len;
              drv_n_clks <= cmd_nbits;
              cmd_ready  <= 1'b0;
              tx_ready   <= 1'b1;
              busy       <= 1'b1;
              state      <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (tx_valid && tx_ready) begin
            drv_tx_data <= tx_data;
            tx_ready    <= 1'b0;
            state       <= S_START;
          end
        end
        S_START: begin
          if (drv_rdy) begin
            drv_start <= 1'b1;
            timer     <= '0;
            state     <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          // The drv_start cycle itself counts as the first timeout cycle
          if (!drv_rdy) begin
            state <= S_WAIT_DONE;
          end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (drv_rdy) begin
            rx_data  <= drv_rx_data;
            rx_valid <= 1'b1;
            rx_last  <= (remaining == LEN_W'(1));
            state    <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (rx_ready) begin
            rx_valid  <= 1'b0;
            rx_last   <= 1'b0;
            remaining <= remaining - 1'b1;
            if (rx_last) begin
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              tx_ready <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// tb/tb_spi_cmd_seq.sv - randomized scoreboard bench for spi_cmd_seq with a loopback driver model
module tb_spi_cmd_seq;
  localparam int SPI_MAXLEN  = 8;
  localparam int MAX_WORDS   = 16;
  localparam int ACK_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_len = '0;
  logic [3:0] cmd_nbits = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = '0;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_last;
  logic       busy;
  logic       err_cmd;
  logic       err_timeout;
  logic       drv_start;
  logic [3:0] drv_n_clks;
  logic [7:0] drv_tx_data;
  logic       drv_rdy;
  logic [7:0] drv_rx_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int exp_nb = 0;
  int n_err_cmd = 0;
  int n_err_to = 0;
  int overlap = 0;
  bit stuck = 1'b0;
  logic [7:0] words [0:31];

  spi_cmd_seq #(
    .SPI_MAXLEN (SPI_MAXLEN),
    .MAX_WORDS  (MAX_WORDS),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_nbits  (cmd_nbits),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_last    (rx_last),
    .busy       (busy),
    .err_cmd    (err_cmd),
    .err_timeout(err_timeout),
    .drv_start  (drv_start),
    .drv_n_clks (drv_n_clks),
    .drv_tx_data(drv_tx_data),
    .drv_rdy    (drv_rdy),
    .drv_rx_data(drv_rx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // spi_drv stand-in: MISO looped to MOSI, busy for a few cycles per word
  initial begin
    int busy_cnt;
    logic [7:0] lat;
    busy_cnt = 0;
    lat = '0;
    drv_rdy = 1'b1;
    drv_rx_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        drv_rdy = 1'b1;
        busy_cnt = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          drv_rx_data = lat;
          drv_rdy = 1'b1;
        end
      end else if (drv_start && !stuck) begin
        lat = drv_tx_data;
        drv_rdy = 1'b0;
        busy_cnt = int'(drv_n_clks) * 2 + int'($urandom_range(1, 3));
      end
    end
  end

  // Monitor: every drv_start must carry the next expected word and the command's bit count
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (drv_start) begin
          check("drv_tx_data", drv_tx_data, words[starts % 32]);
          check("drv_n_clks", drv_n_clks, exp_nb);
          starts++;
        end
        if (err_cmd) n_err_cmd++;
        if (err_timeout) n_err_to++;
        if (tx_ready && rx_valid) overlap++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic issue_cmd(input int len, input int nb);
    int g;
    g = 0;
    while (!cmd_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_len = 5'(len);
    cmd_nbits = 4'(nb);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int len, input int nb, input int hold_cycles, input bit rnd);
    int sent, got, holdcnt, guard, ready_during, not_busy;
    sent = 0; got = 0; holdcnt = 0; guard = 0; ready_during = 0; not_busy = 0;
    starts = 0;
    exp_nb = nb;
    issue_cmd(len, nb);
    while (got < len && guard < 5000) begin
      guard++;
      if (cmd_ready) ready_during++;
      if (!busy) not_busy++;
      if (rx_valid && got == 0 && holdcnt < hold_cycles) begin
        rx_ready = 1'b0;
        check("hold_rx_data", rx_data, words[0]);
        check("hold_tx_ready", tx_ready, 0);
        check("hold_no_start", starts, 1);
        holdcnt++;
      end else begin
        rx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      tx_valid = (sent < len) && (!rnd || $urandom_range(0, 3) != 0);
      tx_data = (sent < len) ? words[sent] : 8'($urandom);
      if (tx_valid && tx_ready) sent++;
      if (rx_valid && rx_ready) begin
        check("rx_data", rx_data, words[got]);
        check("rx_last", rx_last, (got == len - 1));
        got++;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    check("cmd_done", got, len);
    check("tx_sent", sent, len);
    check("starts", starts, len);
    check("cmd_ready_busy", ready_during, 0);
    check("busy_during", not_busy, 0);
    if (hold_cycles > 0) check("hold_len", holdcnt, hold_cycles);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic bad_cmd(input int len, input int nb);
    int e0, tr, bz;
    e0 = n_err_cmd;
    tr = 0; bz = 0;
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    issue_cmd(len, nb);
    check("err_cmd_pulse", err_cmd, 1);
    repeat (6) begin
      if (tx_ready) tr++;
      if (busy) bz++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("err_cmd_once", n_err_cmd - e0, 1);
    check("err_cmd_no_tx", tr, 0);
    check("err_cmd_no_busy", bz, 0);
  endtask

  initial begin
    int g, e0, t0;
    #2;
    check("rst_outs", {cmd_ready, tx_ready, rx_valid, rx_last, busy, err_cmd, err_timeout, drv_start}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);

    // Fixed three-word command, downstream always ready
    words[0] = 8'hEA; words[1] = 8'h55; words[2] = 8'h0F;
    run_cmd(3, 8, 0, 1'b0);

    // Same command with the first rx word back-pressured for 20 cycles
    run_cmd(3, 8, 20, 1'b0);

    // Invalid commands
    bad_cmd(1, 9);
    bad_cmd(0, 8);
    bad_cmd(2, 0);

    // Stuck driver: ready never drops after drv_start
    stuck = 1'b1;
    starts = 0;
    exp_nb = 8;
    words[0] = 8'h96; words[1] = 8'h69;
    e0 = n_err_to;
    issue_cmd(2, 8);
    tx_valid = 1'b1;
    tx_data = 8'h96;
    g = 0;
    while (!drv_start && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("timeout_start_seen", drv_start, 1);
    tx_valid = 1'b0;
    t0 = cyc;
    g = 0;
    while (!err_timeout && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("timeout_delay", cyc - t0, ACK_TIMEOUT);
    check("timeout_busy", busy, 0);
    check("timeout_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    check("timeout_pulse_len", err_timeout, 0);
    check("timeout_once", n_err_to - e0, 1);
    check("timeout_no_tx", tx_ready, 0);
    stuck = 1'b0;

    // Reset while waiting for the transfer to complete
    starts = 0;
    exp_nb = 8;
    words[0] = 8'hC3;
    issue_cmd(1, 8);
    tx_valid = 1'b1;
    tx_data = 8'hC3;
    g = 0;
    while (!drv_start && g < 100) begin
      @(negedge clk);
      g++;
    end
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_drv_rdy", drv_rdy, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {cmd_ready, tx_ready, rx_valid, rx_last, busy, err_cmd, err_timeout, drv_start}, 0);
    check("mid_rst_data", {rx_data, drv_tx_data, drv_n_clks}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    words[0] = 8'hA5;
    run_cmd(1, 8, 0, 1'b0);

    // Back-to-back full-length 4-bit commands
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < MAX_WORDS; i++) words[i] = 8'($urandom);
      run_cmd(MAX_WORDS, 4, 0, 1'b0);
    end

    // Random commands with random source/sink gaps
    for (int k = 0; k < 8; k++) begin
      int len, nb;
      len = int'($urandom_range(1, MAX_WORDS));
      nb = int'($urandom_range(1, SPI_MAXLEN));
      for (int i = 0; i < len; i++) words[i] = 8'($urandom);
      run_cmd(len, nb, 0, 1'b1);
    end

    check("no_overlap", overlap, 0);
    check("err_timeout_total", n_err_to, 1);
    check("err_cmd_total", n_err_cmd, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
